// File: rtl/ntru_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ntru_pkg
// Description : Shared types and constants for the trit packing/unpacking path.
// Revision    : 1.0 - initial release
// ============================================================================
package ntru_pkg;

    typedef logic [1:0] trit_t;

    localparam trit_t TRIT_0 = 2'b00;
    localparam trit_t TRIT_1 = 2'b01;
    localparam trit_t TRIT_2 = 2'b10;

    localparam int          N_TRITS_HRSS   = 700;
    localparam logic [7:0]  BYTE_MAX_TRIT5 = 8'd242;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BYTE = 2'd1,
        ST_EMIT      = 2'd2,
        ST_DONE      = 2'd3
    } unpack_state_t;

endpackage : ntru_pkg
`default_nettype wire

// File: rtl/div3_u8.sv
`default_nettype none
// ============================================================================
// Module      : div3_u8
// Description : Exact combinational divide-by-3 of an 8-bit unsigned value.
// Revision    : 1.0 - initial release
// ============================================================================
module div3_u8 (
    input  logic [7:0] dividend,
    output logic [6:0] quotient,
    output logic [1:0] remainder
);

    // 171/512 overestimates 1/3 by less than 1/1500, exact for all 8-bit inputs
    assign quotient  = 7'((16'(dividend) * 16'd171) >> 9);
    assign remainder = 2'(dividend - (8'(quotient) * 8'd3));

endmodule : div3_u8
`default_nettype wire

// File: rtl/trit5_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : trit5_unpacker
// Description : Unpacks bytes (5 trits each, LS trit first) into a serial
//               coefficient stream. Optional macro TRIT5_RANGE_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module trit5_unpacker #(
    parameter int N_TRITS = 700,
    parameter int CNT_W   = 10
) (
    input  logic       clk,
    input  logic       ovr_rst,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_trit,
    output logic       out_last,
    output logic       done,
    output logic       busy,
    output logic       err_range
);
    import ntru_pkg::*;

    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(N_TRITS - 1);

    unpack_state_t    r_state, w_state_nxt;
    logic [7:0]       r_cur;
    logic [2:0]       r_trit_idx;
    logic [CNT_W-1:0] r_coef_cnt;
    logic [6:0]       w_quo;
    trit_t            w_rem;
    logic             w_final, w_beat, w_accept, w_start_acc;

    div3_u8 u_div3 (
        .dividend  (r_cur),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    assign w_final     = (r_coef_cnt == C_LAST_CNT);
    assign w_beat      = out_valid & out_ready;
    assign w_accept    = in_valid & in_ready;
    assign w_start_acc = (r_state == ST_IDLE) & start;

    always_ff @(posedge clk or posedge ovr_rst) begin
        if (ovr_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_trit    = TRIT_0;
        out_last    = 1'b0;
        done        = 1'b0;
        busy        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) w_state_nxt = ST_WAIT_BYTE;
            end
            ST_WAIT_BYTE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = ST_EMIT;
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                out_trit  = w_rem;
                out_last  = w_final;
                // Overlap: the next byte may land on the fifth-trit beat
                in_ready  = (r_trit_idx == 3'd4) && out_ready && !w_final;
                if (out_ready) begin
                    if (w_final)
                        w_state_nxt = ST_DONE;
                    else if ((r_trit_idx == 3'd4) && !in_valid)
                        w_state_nxt = ST_WAIT_BYTE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge ovr_rst) begin
        if (ovr_rst) begin
            r_cur      <= 8'd0;
            r_trit_idx <= 3'd0;
            r_coef_cnt <= '0;
        end else begin
            if (w_start_acc) begin
                r_coef_cnt <= '0;
                r_trit_idx <= 3'd0;
            end
            if (w_accept) begin
                r_cur      <= in_byte;
                r_trit_idx <= 3'd0;
            end else if (w_beat) begin
                r_cur <= {1'b0, w_quo};
                if (r_trit_idx != 3'd4) r_trit_idx <= r_trit_idx + 3'd1;
            end
            if (w_beat) r_coef_cnt <= r_coef_cnt + CNT_W'(1);
        end
    end

`ifdef TRIT5_RANGE_CHECK_EN
    logic r_err_range;
    logic w_err_set;

    // Partial last byte: whatever remains in the quotient is discarded trits
    assign w_err_set = (w_accept && (in_byte > BYTE_MAX_TRIT5)) ||
                       (w_beat && w_final && (r_trit_idx != 3'd4) && (w_quo != 7'd0));

    always_ff @(posedge clk or posedge ovr_rst) begin
        if (ovr_rst) begin
            r_err_range <= 1'b0;
        end else if (w_start_acc) begin
            r_err_range <= 1'b0;
        end else if (w_err_set) begin
            r_err_range <= 1'b1;
        end
    end

    assign err_range = r_err_range;
`else
    assign err_range = 1'b0;
`endif

endmodule : trit5_unpacker
`default_nettype wire

// File: tb/tb_trit5_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : tb_trit5_unpacker
// Description : Self-checking bench: vector table plus scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trit5_unpacker;

    typedef struct {
        logic [1:0] trit;
        logic       last;
    } exp_t;

    typedef struct {
        logic [7:0] b;
        logic [9:0] trits;
        logic       err;
    } vec_t;

`ifdef TRIT5_RANGE_CHECK_EN
    localparam logic C_CHK = 1'b1;
`else
    localparam logic C_CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       ovr_rst, start_a, start_b, in_valid, out_ready, sel;
    logic [7:0] in_byte;

    logic       a_in_ready, a_out_valid, a_out_last, a_done, a_busy, a_err;
    logic       b_in_ready, b_out_valid, b_out_last, b_done, b_busy, b_err;
    logic [1:0] a_out_trit, b_out_trit;
    logic       m_in_ready, m_valid, m_last, m_done, m_busy, m_err;
    logic [1:0] m_trit;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_idx = 0;
    int   exp_n   = 700;

    always #5 clk = ~clk;

    trit5_unpacker #(.N_TRITS(700), .CNT_W(10)) u_dut_a (
        .clk(clk), .ovr_rst(ovr_rst), .start(start_a),
        .in_valid(in_valid & ~sel), .in_ready(a_in_ready), .in_byte(in_byte),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_trit(a_out_trit),
        .out_last(a_out_last), .done(a_done), .busy(a_busy), .err_range(a_err)
    );

    trit5_unpacker #(.N_TRITS(7), .CNT_W(3)) u_dut_b (
        .clk(clk), .ovr_rst(ovr_rst), .start(start_b),
        .in_valid(in_valid & sel), .in_ready(b_in_ready), .in_byte(in_byte),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_trit(b_out_trit),
        .out_last(b_out_last), .done(b_done), .busy(b_busy), .err_range(b_err)
    );

    assign m_in_ready = sel ? b_in_ready  : a_in_ready;
    assign m_valid    = sel ? b_out_valid : a_out_valid;
    assign m_trit     = sel ? b_out_trit  : a_out_trit;
    assign m_last     = sel ? b_out_last  : a_out_last;
    assign m_done     = sel ? b_done      : a_done;
    assign m_busy     = sel ? b_busy      : a_busy;
    assign m_err      = sel ? b_err       : a_err;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic logic [9:0] unpack5(input int b);
        logic [9:0] r;
        int v;
        v = b;
        for (int k = 0; k < 5; k++) begin
            r[2*k +: 2] = 2'(v % 3);
            v = v / 3;
        end
        return r;
    endfunction

    function automatic void push_trits(input logic [9:0] p);
        for (int k = 0; k < 5; k++) begin
            if (exp_idx < exp_n) begin
                q.push_back('{p[2*k +: 2], exp_idx == exp_n - 1});
                exp_idx++;
            end
        end
    endfunction

    // Scoreboard: the presented trit must match the queue head, stalled or not
    always @(negedge clk) begin
        if (!ovr_rst && m_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got trit %0d, expected no output", m_trit);
            end else begin
                check_eq("trit", 32'(m_trit), 32'(q[0].trit));
                if (out_ready) begin
                    check_eq("out_last", 32'(m_last), 32'(q[0].last));
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic do_reset();
        ovr_rst = 1'b1;
        q.delete();
        @(posedge clk); #1;
        ovr_rst = 1'b0;
    endtask

    task automatic begin_poly(input logic s, input int n);
        sel = s; exp_n = n; exp_idx = 0;
        if (s) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [9:0] p, output int w);
        in_valid = 1'b1;
        in_byte  = b;
        w = 0;
        forever begin
            @(negedge clk);
            w++;
            if (m_in_ready) break;
            if (w > 100) begin
                checks++; errors++;
                $display("FAIL accept_timeout: got no in_ready in %0d cycles, expected accept", w);
                break;
            end
        end
        push_trits(p);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", 32'(q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (m_done || cyc >= 1000) break;
        end
    endtask

    initial begin
        vec_t vecs[4];
        int   w, cyc;
        logic [7:0] rb;

        vecs[0] = '{8'h64, {2'd1, 2'd0, 2'd2, 2'd0, 2'd1}, 1'b0};
        vecs[1] = '{8'h00, 10'h000,                       1'b0};
        vecs[2] = '{8'hF2, 10'h2AA,                       1'b0};
        vecs[3] = '{8'hF3, 10'h000,                       1'b1};

        ovr_rst = 1'b1; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
        in_valid = 1'b0; in_byte = 8'd0; out_ready = 1'b1;
        #1;
        check_eq("rst_in_ready",  32'(a_in_ready),  0);
        check_eq("rst_out_valid", 32'(a_out_valid), 0);
        check_eq("rst_out_trit",  32'(a_out_trit),  0);
        check_eq("rst_out_last",  32'(a_out_last),  0);
        check_eq("rst_done",      32'(a_done),      0);
        check_eq("rst_busy",      32'(a_busy),      0);
        check_eq("rst_err",       32'(a_err),       0);
        @(posedge clk); #1;
        ovr_rst = 1'b0;

        // Single-byte vectors on the 700-trit instance
        for (int i = 0; i < 4; i++) begin
            do_reset();
            begin_poly(1'b0, 700);
            send_byte(vecs[i].b, vecs[i].trits, w);
            check_eq("first_accept_wait", 32'(w), 1);
            drain();
            check_eq("vec_err_range", 32'(m_err), 32'(vecs[i].err & C_CHK));
            check_eq("vec_busy", 32'(m_busy), 1);
            check_eq("vec_wait_in_ready", 32'(m_in_ready), 1);
        end

        // Back-to-back bytes: second accepted on the fifth beat, no bubble
        do_reset();
        begin_poly(1'b0, 700);
        send_byte(8'h00, 10'h000, w);
        send_byte(8'hF2, 10'h2AA, w);
        check_eq("overlap_wait", 32'(w), 5);
        drain();

        // Random consumer stalls
        do_reset();
        begin_poly(1'b0, 700);
        fork
            begin
                send_byte(8'h64, unpack5(100), w);
                send_byte(8'h64, unpack5(100), w);
            end
            begin
                repeat (30) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Full polynomial, no stalls
        do_reset();
        begin_poly(1'b0, 700);
        fork
            for (int i = 0; i < 140; i++) begin
                rb = 8'($urandom_range(0, 242));
                send_byte(rb, unpack5(int'(rb)), w);
            end
            wait_done(cyc);
        join
        check_eq("start_to_done", 32'(cyc), 702);
        check_eq("full_queue_empty", 32'(q.size()), 0);
        @(negedge clk);
        check_eq("done_one_cycle", 32'(m_done), 0);
        check_eq("busy_after", 32'(m_busy), 0);
        @(posedge clk); #1;

        // Partial final byte on the 7-trit instance
        do_reset();
        begin_poly(1'b1, 7);
        send_byte(8'h64, unpack5(100), w);
        send_byte(8'h05, unpack5(5), w);
        wait_done(cyc);
        check_eq("n7_done", 32'(m_done), 1);
        check_eq("n7_queue_empty", 32'(q.size()), 0);
        check_eq("n7_err_clean", 32'(m_err), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        begin_poly(1'b1, 7);
        send_byte(8'h64, unpack5(100), w);
        send_byte(8'h0E, unpack5(14), w);
        wait_done(cyc);
        check_eq("n7_done2", 32'(m_done), 1);
        check_eq("n7_err_pad", 32'(m_err), 32'(C_CHK));
        @(posedge clk); #1;

        // Reset in the middle of a byte, then a clean restart
        do_reset();
        begin_poly(1'b0, 700);
        send_byte(8'hF3, 10'h000, w);
        @(posedge clk); #1;
        ovr_rst = 1'b1;
        q.delete();
        #1;
        check_eq("mid_rst_out_valid", 32'(a_out_valid), 0);
        check_eq("mid_rst_out_trit",  32'(a_out_trit),  0);
        check_eq("mid_rst_busy",      32'(a_busy),      0);
        check_eq("mid_rst_in_ready",  32'(a_in_ready),  0);
        check_eq("mid_rst_err",       32'(a_err),       0);
        @(posedge clk); #1;
        ovr_rst = 1'b0;
        begin_poly(1'b0, 700);
        check_eq("restart_busy", 32'(a_busy), 1);
        send_byte(8'h64, unpack5(100), w);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_trit5_unpacker
`default_nettype wire
